mor1kx_fetch_tcm_prefetch: RTL and testbench



---
 rtl/mor1kx_fetch_tcm_prefetch.sv | 205 ++++++++++++++++++++
 tb/tb_mor1kx_fetch_tcm_prefetch.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mor1kx_fetch_tcm_prefetch.sv
// TCM instruction fetch with a parametrised prefetch FIFO, in-order read tracking,
// stale-response dropping after redirects, and sleep on jump-to-self.
//   state | meaning
//   RUN   | issuing requests and delivering to decode
//   SLEEP | jump-to-self instruction reached decode; waits for a redirect
//   HALT  | bus-errored entry reached decode; waits for a redirect
module mor1kx_fetch_tcm_prefetch #(
    parameter int                              OPTION_OPERAND_WIDTH = 32,
    parameter logic [OPTION_OPERAND_WIDTH-1:0] OPTION_RESET_PC      = 'h100,
    parameter int                              FIFO_DEPTH           = 4,
    parameter bit                              OPTION_SLEEP_ON_JTS  = 1'b1
) (
    input  logic                              clk,
    input  logic                              rst,
    output logic [OPTION_OPERAND_WIDTH-1:0]   ibus_adr_o,
    output logic                              ibus_req_o,
    input  logic                              ibus_ack_i,
    input  logic                              ibus_err_i,
    input  logic [31:0]                       ibus_dat_i,
    input  logic                              padv_i,
    output logic                              fetch_ready_o,
    output logic [31:0]                       decode_insn_o,
    output logic [OPTION_OPERAND_WIDTH-1:0]   fetched_pc_o,
    output logic                              decode_except_ibus_err_o,
    input  logic                              branch_occur_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0]   branch_dest_i,
    input  logic                              fetch_take_exception_branch_i,
    input  logic                              du_restart_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0]   du_restart_pc_i,
    input  logic                              du_stall_i,
    output logic                              fetch_sleep_o,
    output logic [$clog2(FIFO_DEPTH):0]       fifo_level_o
);

    localparam int AW = OPTION_OPERAND_WIDTH;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = PW + 1;
    localparam logic [31:0]   NOP_INSN     = 32'h15000000;
    localparam logic [LW:0]   DEPTH_CREDIT = (LW+1)'(FIFO_DEPTH);
    localparam logic [LW-1:0] DEPTH_LVL    = LW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_SLEEP = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   fetch_pc_q, fetch_pc_d;
    logic [AW-1:0]   resp_pc_q, resp_pc_d;
    logic [LW-1:0]   level_q, level_d;
    logic [LW-1:0]   outst_q, outst_d;
    logic [LW-1:0]   drop_q, drop_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [31:0]     insn_q, insn_d;
    logic [AW-1:0]   fpc_q, fpc_d;
    logic            err_q, err_d;

    logic [31:0]     fifo_dat_q [FIFO_DEPTH];
    logic [AW-1:0]   fifo_pc_q  [FIFO_DEPTH];
    logic            fifo_err_q [FIFO_DEPTH];

    logic            redirect;
    logic [AW-1:0]   target;
    logic            fifo_empty;
    logic            ack_accept;
    logic [LW:0]     credit_used;
    logic            req;
    logic            ready;
    logic            consume;
    logic            push;
    logic            pop;
    logic [31:0]     load_dat;
    logic [AW-1:0]   load_pc;
    logic            load_err;

    always_comb begin
        redirect    = du_restart_i | fetch_take_exception_branch_i | (branch_occur_i & padv_i);
        target      = du_restart_i ? du_restart_pc_i : branch_dest_i;
        fifo_empty  = (level_q == '0);
        ack_accept  = ibus_ack_i & (drop_q == '0);
        // Reads in flight count against FIFO space so an accepted ack always has a slot.
        credit_used = {1'b0, level_q} + {1'b0, outst_q};
        req         = !rst & (state_q == ST_RUN) & !du_stall_i & !redirect &
                      (credit_used < DEPTH_CREDIT);
        ready       = !rst & (state_q == ST_RUN) & !redirect & (!fifo_empty | ack_accept);
        consume     = padv_i & ready;
        pop         = consume & !fifo_empty;
        push        = ack_accept & !redirect & !(consume & fifo_empty);
        if (fifo_empty) begin
            load_dat = ibus_dat_i;
            load_pc  = resp_pc_q;
            load_err = ibus_err_i;
        end else begin
            load_dat = fifo_dat_q[rd_ptr_q];
            load_pc  = fifo_pc_q[rd_ptr_q];
            load_err = fifo_err_q[rd_ptr_q];
        end
    end

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        level_d    = level_q;
        outst_d    = outst_q;
        drop_d     = drop_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        insn_d     = insn_q;
        fpc_d      = fpc_q;
        err_d      = err_q;

        if (req) fetch_pc_d = fetch_pc_q + AW'(4);
        if (ack_accept) resp_pc_d = resp_pc_q + AW'(4);

        case ({req, ibus_ack_i})
            2'b10:   outst_d = outst_q + LW'(1);
            2'b01:   outst_d = outst_q - LW'(1);
            default: outst_d = outst_q;
        endcase

        if (ibus_ack_i && !ack_accept) drop_d = drop_q - LW'(1);

        if (push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        if (push && !pop)      level_d = level_q + LW'(1);
        else if (pop && !push) level_d = level_q - LW'(1);

        if (consume) begin
            insn_d = load_dat;
            fpc_d  = load_pc;
            err_d  = load_err;
            if (load_err)                               state_d = ST_HALT;
            else if (OPTION_SLEEP_ON_JTS && load_dat == '0) state_d = ST_SLEEP;
        end else if (padv_i) begin
            insn_d = NOP_INSN;
            err_d  = 1'b0;
        end

        // Everything still in flight belongs to the abandoned path and is dropped on return.
        if (redirect) begin
            fetch_pc_d = target;
            resp_pc_d  = target;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            level_d    = '0;
            drop_d     = outst_q - LW'(ibus_ack_i);
            insn_d     = NOP_INSN;
            err_d      = 1'b0;
            state_d    = ST_RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_RUN;
            fetch_pc_q <= OPTION_RESET_PC;
            resp_pc_q  <= OPTION_RESET_PC;
            level_q    <= '0;
            outst_q    <= '0;
            drop_q     <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            insn_q     <= NOP_INSN;
            fpc_q      <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            level_q    <= level_d;
            outst_q    <= outst_d;
            drop_q     <= drop_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            insn_q     <= insn_d;
            fpc_q      <= fpc_d;
            err_q      <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_dat_q[wr_ptr_q] <= ibus_dat_i;
            fifo_pc_q[wr_ptr_q]  <= resp_pc_q;
            fifo_err_q[wr_ptr_q] <= ibus_err_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push) assert (level_q != DEPTH_LVL);
    end

    assign ibus_req_o               = req;
    assign ibus_adr_o               = fetch_pc_q;
    assign fetch_ready_o            = ready;
    assign decode_insn_o            = insn_q;
    assign fetched_pc_o             = fpc_q;
    assign decode_except_ibus_err_o = err_q;
    assign fetch_sleep_o            = (state_q == ST_SLEEP);
    assign fifo_level_o             = level_q;

endmodule

// File: tb/tb_mor1kx_fetch_tcm_prefetch.sv
// Bench for the TCM prefetch fetch unit: directed scenarios then a randomized phase,
// checked against a queue-based model of the instruction stream.
module tb_mor1kx_fetch_tcm_prefetch;

    localparam int          DEPTH  = 4;
    localparam logic [31:0] NOP    = 32'h15000000;
    localparam int          M_RUN  = 0;
    localparam int          M_SLP  = 1;
    localparam int          M_HALT = 2;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [31:0] ibus_adr_o;
    logic        ibus_req_o;
    logic        ibus_ack_i;
    logic        ibus_err_i;
    logic [31:0] ibus_dat_i;
    logic        padv_i;
    logic        fetch_ready_o;
    logic [31:0] decode_insn_o;
    logic [31:0] fetched_pc_o;
    logic        decode_except_ibus_err_o;
    logic        branch_occur_i;
    logic [31:0] branch_dest_i;
    logic        fetch_take_exception_branch_i;
    logic        du_restart_i;
    logic [31:0] du_restart_pc_i;
    logic        du_stall_i;
    logic        fetch_sleep_o;
    logic [2:0]  fifo_level_o;

    mor1kx_fetch_tcm_prefetch dut (
        .clk                           (clk),
        .rst                           (rst),
        .ibus_adr_o                    (ibus_adr_o),
        .ibus_req_o                    (ibus_req_o),
        .ibus_ack_i                    (ibus_ack_i),
        .ibus_err_i                    (ibus_err_i),
        .ibus_dat_i                    (ibus_dat_i),
        .padv_i                        (padv_i),
        .fetch_ready_o                 (fetch_ready_o),
        .decode_insn_o                 (decode_insn_o),
        .fetched_pc_o                  (fetched_pc_o),
        .decode_except_ibus_err_o      (decode_except_ibus_err_o),
        .branch_occur_i                (branch_occur_i),
        .branch_dest_i                 (branch_dest_i),
        .fetch_take_exception_branch_i (fetch_take_exception_branch_i),
        .du_restart_i                  (du_restart_i),
        .du_restart_pc_i               (du_restart_pc_i),
        .du_stall_i                    (du_stall_i),
        .fetch_sleep_o                 (fetch_sleep_o),
        .fifo_level_o                  (fifo_level_o)
    );

    typedef struct packed {
        logic [31:0] adr;
        int          ep;
    } pend_t;

    typedef struct packed {
        logic [31:0] dat;
        logic [31:0] pc;
        logic        err;
    } ent_t;

    int          checks   = 0;
    int          failures = 0;
    pend_t       pend_q[$];
    ent_t        avail_q[$];
    int          epoch;
    int          mode;
    int          ack_pct;
    logic [31:0] m_req_pc;
    logic [31:0] m_insn;
    logic [31:0] m_pc;
    logic        m_err;
    logic [31:0] jts_addr;
    logic [31:0] err_addr;
    logic [31:0] last_err_pc;

    function automatic logic [31:0] mem(input logic [31:0] a);
        if (a == jts_addr) return 32'h0;
        return a ^ 32'h5A000001;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: memory responds, model predicts, combinational outputs checked mid-cycle,
    // registered outputs checked just after the edge.
    task automatic step();
        logic        ack_now, ack_ok, redir, exp_req, exp_rdy;
        logic [31:0] tgt;
        pend_t       p;
        ent_t        e;
        p = '0;
        ack_now = (pend_q.size() > 0) && ($urandom_range(99) < ack_pct);
        ibus_ack_i = ack_now;
        if (ack_now) begin
            p = pend_q[0];
            ibus_dat_i = mem(p.adr);
            ibus_err_i = (p.adr == err_addr);
        end else begin
            ibus_dat_i = $urandom;
            ibus_err_i = 1'($urandom_range(1));
        end
        @(negedge clk);
        redir   = du_restart_i | fetch_take_exception_branch_i | (branch_occur_i & padv_i);
        tgt     = du_restart_i ? du_restart_pc_i : branch_dest_i;
        ack_ok  = ack_now && (p.ep == epoch);
        exp_req = (mode == M_RUN) && !du_stall_i && !redir &&
                  (avail_q.size() + pend_q.size() < DEPTH);
        exp_rdy = (mode == M_RUN) && !redir && (avail_q.size() > 0 || ack_ok);
        chk("ibus_req", 32'(ibus_req_o), 32'(exp_req));
        if (exp_req) chk("ibus_adr", ibus_adr_o, m_req_pc);
        chk("fetch_ready", 32'(fetch_ready_o), 32'(exp_rdy));

        if (ack_now) void'(pend_q.pop_front());
        if (ack_ok) begin
            e.dat = ibus_dat_i;
            e.pc  = p.adr;
            e.err = ibus_err_i;
            avail_q.push_back(e);
        end
        if (exp_req) begin
            pend_q.push_back('{adr: m_req_pc, ep: epoch});
            m_req_pc = m_req_pc + 32'd4;
        end
        if (redir) begin
            avail_q.delete();
            epoch++;
            m_req_pc = tgt;
            m_insn   = NOP;
            m_err    = 1'b0;
            mode     = M_RUN;
        end else if (padv_i && exp_rdy) begin
            e      = avail_q.pop_front();
            m_insn = e.dat;
            m_pc   = e.pc;
            m_err  = e.err;
            if (e.err)             mode = M_HALT;
            else if (e.dat == '0)  mode = M_SLP;
        end else if (padv_i) begin
            m_insn = NOP;
            m_err  = 1'b0;
        end

        @(posedge clk);
        #1;
        chk("decode_insn", decode_insn_o, m_insn);
        chk("fetched_pc", fetched_pc_o, m_pc);
        chk("decode_err", 32'(decode_except_ibus_err_o), 32'(m_err));
        chk("sleep", 32'(fetch_sleep_o), 32'(mode == M_SLP));
        chk("fifo_level", 32'(fifo_level_o), avail_q.size());
        if (decode_except_ibus_err_o === 1'b1) last_err_pc = fetched_pc_o;
        branch_occur_i                = 1'b0;
        fetch_take_exception_branch_i = 1'b0;
        du_restart_i                  = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        ibus_ack_i = 1'b0;
        ibus_err_i = 1'b0;
        ibus_dat_i = '0;
        padv_i = 1'b0;
        branch_occur_i = 1'b0;
        branch_dest_i = '0;
        fetch_take_exception_branch_i = 1'b0;
        du_restart_i = 1'b0;
        du_restart_pc_i = '0;
        du_stall_i = 1'b0;
        ack_pct = 100;
        jts_addr = 32'hFFFFFFFF;
        err_addr = 32'h00000001;
        last_err_pc = '0;
        epoch = 0;
        mode = M_RUN;
        m_req_pc = 32'h100;
        m_insn = NOP;
        m_pc = '0;
        m_err = 1'b0;

        @(negedge clk);
        chk("req_in_rst", 32'(ibus_req_o), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_insn", decode_insn_o, NOP);
        chk("rst_pc", fetched_pc_o, 32'd0);
        chk("rst_err", 32'(decode_except_ibus_err_o), 32'd0);
        chk("rst_sleep", 32'(fetch_sleep_o), 32'd0);
        chk("rst_level", 32'(fifo_level_o), 32'd0);
        chk("rst_adr", ibus_adr_o, 32'h100);

        // Streaming with zero-latency bypass.
        padv_i = 1'b1;
        repeat (8) step();
        chk("stream_level", 32'(fifo_level_o), 32'd0);

        // Decode stalled: FIFO fills to depth and requests stop.
        padv_i = 1'b0;
        repeat (6) step();
        chk("full_level", 32'(fifo_level_o), 32'd4);
        chk("full_noreq", 32'(ibus_req_o), 32'd0);
        padv_i = 1'b1;
        repeat (8) step();

        // Branch with reads in flight.
        ack_pct = 0;
        repeat (2) step();
        branch_occur_i = 1'b1;
        branch_dest_i  = 32'h2000;
        ack_pct = 100;
        step();
        repeat (8) step();

        // Bus error at 0x108, then exception redirect.
        err_addr = 32'h108;
        du_restart_i = 1'b1;
        du_restart_pc_i = 32'h100;
        last_err_pc = '0;
        step();
        repeat (10) step();
        chk("err_pc", last_err_pc, 32'h108);
        chk("halt_noreq", 32'(ibus_req_o), 32'd0);
        err_addr = 32'h00000001;
        fetch_take_exception_branch_i = 1'b1;
        branch_dest_i = 32'h600;
        step();
        repeat (6) step();
        chk("exc_err_clear", 32'(decode_except_ibus_err_o), 32'd0);

        // Jump-to-self at 0x110, then debug restart.
        jts_addr = 32'h110;
        du_restart_i = 1'b1;
        du_restart_pc_i = 32'h100;
        step();
        repeat (12) step();
        chk("jts_sleep", 32'(fetch_sleep_o), 32'd1);
        chk("jts_noreq", 32'(ibus_req_o), 32'd0);
        jts_addr = 32'hFFFFFFFF;
        du_restart_i = 1'b1;
        step();
        repeat (8) step();
        chk("restart_awake", 32'(fetch_sleep_o), 32'd0);

        // Address wrap past 0xFFFFFFFC.
        branch_occur_i = 1'b1;
        branch_dest_i  = 32'hFFFFFFF8;
        step();
        repeat (8) step();

        // Randomized traffic.
        err_addr = 32'h1040;
        jts_addr = 32'h1080;
        ack_pct  = 60;
        for (int i = 0; i < 800; i++) begin
            padv_i                        = ($urandom_range(99) < 70);
            du_stall_i                    = ($urandom_range(99) < 10);
            branch_dest_i                 = 32'h1000 + 32'($urandom_range(63) << 2);
            branch_occur_i                = ($urandom_range(99) < 4);
            fetch_take_exception_branch_i = ($urandom_range(99) < 2);
            du_restart_i                  = ($urandom_range(99) < 2);
            du_restart_pc_i               = 32'h1000 + 32'($urandom_range(63) << 2);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
